rx_dec_seq_ctrl: RTL
====================

Name: rx_dec_seq_ctrl

Overview:
Receive-side sequencer that drives the lane decoder's `enable_dec` and keeps a byte-slot counter aligned with the decoder's internal byte index. It accepts encoded blocks from the deserializer over a valid/ready handshake, one block per decoder period: 1 cycle at Gen4, 8 at Gen2, 16 at Gen3. It also detects underruns, speed changes and link drop, re-arms the decoder cleanly after each, and sits between the deserializer and the decoding block.

Parameters:
SETTLE_CYC, 4, cycles `enable_dec` stays low after a gen_speed change before re-arming (1..15)
ERR_W, 8, width of the saturating underrun counter

Ports:
enc_clk  in  1  encoder/decoder clock
rst  in  1  asynchronous, active-low reset
link_en  in  1  decoder path enabled by link training; low forces IDLE
gen_speed  in  2  00=Gen4, 10=Gen2, 01=Gen3, 11=reserved
blk_valid  in  1  deserializer has a complete encoded block on both lanes
blk_ready  out  1  controller accepts the block this cycle
enable_dec  out  1  decoder enable
byte_cnt  out  4  mirror of the decoder's byte index
dec_active  out  1  high in RUN
underrun  out  1  one-cycle pulse: block missing at a period boundary
underrun_cnt  out  ERR_W  saturating count of underruns
cnt_clr  in  1  synchronous clear of underrun_cnt

Behaviour:
- max_byte(spd): Gen4=0, Gen2=7, Gen3=15, reserved=1. `spd_q` is the registered gen_speed.
- States: IDLE, ARM, RUN, SETTLE.
- Reset values: state=IDLE, enable_dec=0, dec_active=0, underrun=0, underrun_cnt=0, byte_cnt=0, spd_q=gen_speed sampled 0, settle counter=0.
- blk_ready is decoded from registered state only, with no combinational path from blk_valid: blk_ready = (state==ARM) | (state==RUN & byte_cnt==max_byte(spd_q)).
- A transfer occurs when blk_valid & blk_ready. blk_valid while blk_ready is low is not an error; upstream holds the block.
- IDLE:
  - enable_dec=0; byte_cnt<=max_byte(gen_speed); spd_q tracks gen_speed every cycle.
  - link_en=1 -> ARM.
- ARM:
  - enable_dec=0; byte_cnt held at max_byte(spd_q).
  - A transfer -> RUN; enable_dec=1 and byte_cnt=0 take effect the next cycle (1-cycle latency).
- RUN:
  - enable_dec=1.
  - byte_cnt increments each cycle and wraps max->0. Gen4 stays at 0.
  - At byte_cnt==max: a transfer continues RUN with no bubble.
  - At byte_cnt==max with no blk_valid -> ARM. In the same cycle: underrun pulse, underrun_cnt+1 (saturating at all-ones), enable_dec low next cycle, byte_cnt<=max.
- SETTLE:
  - enable_dec=0; settle counter loaded with SETTLE_CYC-1 on entry and decremented each cycle.
  - At 0 -> ARM. byte_cnt<=max_byte(spd_q).
- Speed change: in ARM/RUN/SETTLE, gen_speed!=spd_q -> SETTLE. spd_q updates and the settle counter reloads. A change arriving during SETTLE restarts the settle count.
- Priority when events coincide: link_en=0 (-> IDLE next cycle from any state; no underrun counted) > speed change > underrun/transfer.
- Reserved gen_speed (11): treated as a normal speed with max=1; no special error.
- cnt_clr has priority over an increment in the same cycle (result 0).
- Async reset mid-RUN: enable_dec drops immediately (asynchronously); the held block is discarded.

Decomposition:
- Shared package `usb4_rx_pkg`:
  - gen_speed encodings GEN4/GEN2/GEN3
  - `max_byte` function
  - state enum {IDLE, ARM, RUN, SETTLE}
- The decoder constants must come from this same package.
- One natural sub-module: `sat_counter` (parameterised width, inc, clr), used for underrun_cnt.

Test Plan:
1. Reset, link_en=1, Gen2, blk_valid held high -> blk_ready in ARM; enable_dec=1 one cycle after the transfer; byte_cnt 0..7 repeats; blk_ready high only at byte_cnt=7; underrun_cnt stays 0.
2. Gen3 running, blk_valid dropped at the byte_cnt=15 boundary -> underrun pulses one cycle; underrun_cnt=1; enable_dec=0 next cycle; byte_cnt=15; state ARM; the next valid resumes RUN.
3. Gen4 running with valid every cycle, then gen_speed changed to 01 -> enable_dec=0 for exactly 4 cycles (SETTLE_CYC=4); then ARM; then RUN with byte_cnt period 16.
4. Link drop coinciding with an underrun boundary at Gen2 -> state IDLE next cycle; underrun not pulsed; underrun_cnt unchanged.
5. ERR_W=2, force 5 underruns -> underrun_cnt saturates at 3; cnt_clr together with a 6th underrun -> 0.
6. rst asserted asynchronously mid-RUN at byte_cnt=4 -> enable_dec, blk_ready and dec_active are 0 immediately; after release, the sequencer restarts from IDLE.

Source files
------------

// File: rtl/usb4_rx_pkg.sv
// Shared receive-path constants: gen_speed encodings, decoder byte-index limits
// and the sequencer state type.
package usb4_rx_pkg;

  localparam logic [1:0] GEN4 = 2'b00;
  localparam logic [1:0] GEN2 = 2'b10;
  localparam logic [1:0] GEN3 = 2'b01;

  localparam int BYTE_W   = 4;
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    SETTLE
  } seq_state_e;

  // Last byte index of one decoder period; the reserved code decodes as a 2-byte period.
  function automatic logic [BYTE_W-1:0] max_byte(input logic [1:0] spd);
    case (spd)
      GEN4:    max_byte = 4'd0;
      GEN2:    max_byte = 4'd7;
      GEN3:    max_byte = 4'd15;
      default: max_byte = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/rx_dec_seq_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             enc_clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rx_dec_seq_ctrl.sv
// Receive-side decoder sequencer: paces block acceptance to the decoder period,
// tracks the decoder byte index and re-arms after underrun, speed change or link drop.
module rx_dec_seq_ctrl
  import usb4_rx_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int ERR_W      = 8
) (
  input  logic              enc_clk,
  input  logic              rst,
  input  logic              link_en,
  input  logic [1:0]        gen_speed,
  input  logic              blk_valid,
  output logic              blk_ready,
  output logic              enable_dec,
  output logic [BYTE_W-1:0] byte_cnt,
  output logic              dec_active,
  output logic              underrun,
  output logic [ERR_W-1:0]  underrun_cnt,
  input  logic              cnt_clr
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);

  seq_state_e          state_q,    state_d;
  logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [1:0]          spd_q,      spd_d;
  logic [SETTLE_W-1:0] settle_q,   settle_d;

  logic at_max;
  logic xfer;
  logic spd_chg;
  logic underrun_evt;

  // Ready comes from registered state only so upstream sees no path from blk_valid.
  assign at_max    = (byte_cnt_q == max_byte(spd_q));
  assign blk_ready = (state_q == ARM) || ((state_q == RUN) && at_max);
  assign xfer      = blk_valid && blk_ready;
  assign spd_chg   = (gen_speed != spd_q);

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    spd_d        = spd_q;
    settle_d     = settle_q;
    underrun_evt = 1'b0;

    if (state_q == IDLE) begin
      spd_d      = gen_speed;
      byte_cnt_d = max_byte(gen_speed);
      if (link_en) begin
        state_d = ARM;
      end
    end else if (!link_en) begin
      state_d    = IDLE;
      byte_cnt_d = max_byte(spd_q);
    end else if (spd_chg) begin
      // A block accepted in this cycle is dropped: the decoder restarts at the new rate.
      state_d    = SETTLE;
      spd_d      = gen_speed;
      settle_d   = SETTLE_LOAD;
      byte_cnt_d = max_byte(gen_speed);
    end else begin
      case (state_q)
        ARM: begin
          byte_cnt_d = max_byte(spd_q);
          if (xfer) begin
            state_d    = RUN;
            byte_cnt_d = '0;
          end
        end
        RUN: begin
          if (!at_max) begin
            byte_cnt_d = byte_cnt_q + BYTE_W'(1);
          end else if (xfer) begin
            byte_cnt_d = '0;
          end else begin
            state_d      = ARM;
            underrun_evt = 1'b1;
          end
        end
        SETTLE: begin
          byte_cnt_d = max_byte(spd_q);
          if (settle_q == '0) begin
            state_d = ARM;
          end else begin
            settle_d = settle_q - SETTLE_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      spd_q      <= 2'b00;
      settle_q   <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      spd_q      <= spd_d;
      settle_q   <= settle_d;
    end
  end

  sat_counter #(
    .WIDTH(ERR_W)
  ) u_underrun_cnt (
    .enc_clk(enc_clk),
    .rst    (rst),
    .inc    (underrun_evt),
    .clr    (cnt_clr),
    .cnt    (underrun_cnt)
  );

  // Decoded from state so an asynchronous reset drops the enable at once.
  assign enable_dec = (state_q == RUN);
  assign dec_active = (state_q == RUN);
  assign byte_cnt   = byte_cnt_q;
  assign underrun   = underrun_evt;

endmodule
